// File: rtl/alu_pkg.sv
// Shared opcodes, FSM state encoding and flag
// bit positions for the iterative ALU.
package alu_pkg;

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SHL1 = 4'h1;
  localparam logic [3:0] OP_SHR1 = 4'h2;
  localparam logic [3:0] OP_AND  = 4'h3;
  localparam logic [3:0] OP_OR   = 4'h4;
  localparam logic [3:0] OP_XOR  = 4'h5;
  localparam logic [3:0] OP_SUB  = 4'h6;
  localparam logic [3:0] OP_MOV  = 4'h7;
  localparam logic [3:0] OP_SLT  = 4'h8;
  localparam logic [3:0] OP_MUL  = 4'h9;
  localparam logic [3:0] OP_SLLV = 4'hA;
  localparam logic [3:0] OP_SRLV = 4'hB;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  localparam int FLG_Z = 0;
  localparam int FLG_C = 1;
  localparam int FLG_V = 2;
  localparam int FLG_N = 3;

  typedef logic [FLG_N-1:0] flags_t;

  function automatic flags_t mk_flags(
    input logic z,
    input logic c,
    input logic v
  );
    flags_t f;
    f        = '0;
    f[FLG_Z] = z;
    f[FLG_C] = c;
    f[FLG_V] = v;
    return f;
  endfunction

endpackage

// File: rtl/alu_mul_seq.sv
// Shift-add unsigned multiplier, one partial
// product per cycle, W cycles after start.
module alu_mul_seq
  import alu_pkg::*;
#(
  parameter int W = 8
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic           start_i,
  input  logic [W-1:0]   a_i,
  input  logic [W-1:0]   b_i,
  output logic [2*W-1:0] prod_o,
  output logic           done_o
);

  localparam int CW = $clog2(W) + 1;

  logic [W-1:0]   mcand_q, mcand_d;
  logic [2*W-1:0] p_q, p_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           run_q, run_d;
  logic [W:0]     add_w;
  logic [2*W-1:0] p_step;

  // One iteration: add multiplicand into the high half
  // when the current multiplier bit is set, then shift.
  always_comb begin
    add_w  = {1'b0, p_q[2*W-1:W]}
           + (p_q[0] ? {1'b0, mcand_q} : '0);
    p_step = {add_w, p_q[W-1:1]};
  end

  // prod_o shows the value this cycle's step produces,
  // so the caller can latch it on the final edge.
  assign prod_o = p_step;
  assign done_o = run_q && (cnt_q == CW'(1));

  // Load operands on start, otherwise iterate while running.
  always_comb begin
    mcand_d = mcand_q;
    p_d     = p_q;
    cnt_d   = cnt_q;
    run_d   = run_q;
    if (start_i) begin
      mcand_d = a_i;
      p_d     = {{W{1'b0}}, b_i};
      cnt_d   = CW'(W);
      run_d   = 1'b1;
    end else if (run_q) begin
      p_d   = p_step;
      cnt_d = cnt_q - CW'(1);
      if (cnt_q == CW'(1)) run_d = 1'b0;
    end
  end

  // Multiplier state registers with synchronous clear.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mcand_q <= '0;
      p_q     <= '0;
      cnt_q   <= '0;
      run_q   <= 1'b0;
    end else begin
      mcand_q <= mcand_d;
      p_q     <= p_d;
      cnt_q   <= cnt_d;
      run_q   <= run_d;
    end
  end

endmodule

// File: rtl/alu_iterative.sv
// ALU with registered results and flags; MUL and
// variable shifts run iteratively behind Busy/Done.
module alu_iterative
  import alu_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic         Start,
  input  logic [3:0]   OP,
  input  logic [W-1:0] InputA,
  input  logic [W-1:0] InputB,
  output logic [W-1:0] Out,
  output logic [W-1:0] OutHi,
  output logic         Zero,
  output logic         Carry,
  output logic         Overflow,
  output logic         Busy,
  output logic         Done
);

  localparam int SH_W = $clog2(W);
  localparam int CW   = SH_W + 1;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [3:0]      op_q, op_d;
  logic [W-1:0]    sh_q, sh_d;
  logic [W-1:0]    out_q, out_d;
  logic [W-1:0]    hi_q, hi_d;
  flags_t          flg_q, flg_d;
  logic            done_q, done_d;

  logic [SH_W-1:0] amt;
  logic            is_mul, is_sh, is_long;
  logic            mul_go, mul_done;
  logic [2*W-1:0]  mul_prod;

  logic [W:0]      add_w, sub_w;
  logic [W-1:0]    sc_res;
  logic            sc_c, sc_v;
  logic [W-1:0]    sh_nx;
  logic            sh_c;

  assign amt     = InputB[SH_W-1:0];
  assign is_mul  = (OP == OP_MUL);
  assign is_sh   = (OP == OP_SLLV) || (OP == OP_SRLV);
  assign is_long = is_mul || (is_sh && (amt > SH_W'(1)));
  assign mul_go  = (state_q == ST_IDLE) && Start && is_mul;

  alu_mul_seq #(.W(W)) u_mul (
    .clk_i   (Clk),
    .rst_i   (Reset),
    .start_i (mul_go),
    .a_i     (InputA),
    .b_i     (InputB),
    .prod_o  (mul_prod),
    .done_o  (mul_done)
  );

  // Single-cycle result and flags straight from the operands.
  // Shifts only land here when the amount is 0 or 1.
  always_comb begin
    add_w  = {1'b0, InputA} + {1'b0, InputB};
    sub_w  = {1'b0, InputA} - {1'b0, InputB};
    sc_res = '0;
    sc_c   = 1'b0;
    sc_v   = 1'b0;
    case (OP)
      OP_ADD: begin
        sc_res = add_w[W-1:0];
        sc_c   = add_w[W];
        sc_v   = (InputA[W-1] == InputB[W-1])
               & (add_w[W-1] ^ InputA[W-1]);
      end
      OP_SUB: begin
        sc_res = sub_w[W-1:0];
        sc_c   = sub_w[W];
        sc_v   = (InputA[W-1] ^ InputB[W-1])
               & (sub_w[W-1] ^ InputA[W-1]);
      end
      OP_SHL1: begin
        sc_res = InputA << 1;
        sc_c   = InputA[W-1];
      end
      OP_SHR1: begin
        sc_res = InputA >> 1;
        sc_c   = InputA[0];
      end
      OP_AND: sc_res = InputA & InputB;
      OP_OR:  sc_res = InputA | InputB;
      OP_XOR: sc_res = InputA ^ InputB;
      OP_MOV: sc_res = InputB;
      OP_SLT: sc_res = {{(W-1){1'b0}},
                        $signed(InputA) < $signed(InputB)};
      OP_SLLV: begin
        if (amt == '0) begin
          sc_res = InputA;
        end else begin
          sc_res = InputA << 1;
          sc_c   = InputA[W-1];
        end
      end
      OP_SRLV: begin
        if (amt == '0) begin
          sc_res = InputA;
        end else begin
          sc_res = InputA >> 1;
          sc_c   = InputA[0];
        end
      end
      default: sc_res = '0;
    endcase
  end

  // One bit of an in-flight variable shift.
  always_comb begin
    if (op_q == OP_SLLV) begin
      sh_nx = sh_q << 1;
      sh_c  = sh_q[W-1];
    end else begin
      sh_nx = sh_q >> 1;
      sh_c  = sh_q[0];
    end
  end

  // FSM next state, iteration counter and result capture.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    sh_d    = sh_q;
    out_d   = out_q;
    hi_d    = hi_q;
    flg_d   = flg_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (Start) begin
          if (is_long) begin
            state_d = ST_RUN;
            op_d    = OP;
            sh_d    = InputA;
            cnt_d   = is_mul ? CW'(W) : {1'b0, amt};
          end else begin
            out_d  = sc_res;
            hi_d   = '0;
            flg_d  = mk_flags(sc_res == '0, sc_c, sc_v);
            done_d = 1'b1;
          end
        end
      end
      ST_RUN: begin
        cnt_d = cnt_q - CW'(1);
        if (op_q == OP_MUL) begin
          if (mul_done) begin
            out_d   = mul_prod[W-1:0];
            hi_d    = mul_prod[2*W-1:W];
            flg_d   = mk_flags(mul_prod == '0, 1'b0,
                               mul_prod[2*W-1:W] != '0);
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end
        end else begin
          sh_d = sh_nx;
          if (cnt_q == CW'(1)) begin
            out_d   = sh_nx;
            hi_d    = '0;
            flg_d   = mk_flags(sh_nx == '0, sh_c, 1'b0);
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers; reset drops any op in flight.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      sh_q    <= '0;
      out_q   <= '0;
      hi_q    <= '0;
      flg_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      sh_q    <= sh_d;
      out_q   <= out_d;
      hi_q    <= hi_d;
      flg_q   <= flg_d;
      done_q  <= done_d;
    end
  end

  assign Out      = out_q;
  assign OutHi    = hi_q;
  assign Zero     = flg_q[FLG_Z];
  assign Carry    = flg_q[FLG_C];
  assign Overflow = flg_q[FLG_V];
  assign Busy     = (state_q == ST_RUN);
  assign Done     = done_q;

endmodule

// File: tb/tb_alu_iterative.sv
// Self-checking bench for alu_iterative: vector
// table, random ops vs. a model, handshake corners.
module tb_alu_iterative;

  localparam int W = 8;

  logic         Clk = 1'b0;
  logic         Reset;
  logic         Start;
  logic [3:0]   OP;
  logic [W-1:0] InputA;
  logic [W-1:0] InputB;
  logic [W-1:0] Out;
  logic [W-1:0] OutHi;
  logic         Zero;
  logic         Carry;
  logic         Overflow;
  logic         Busy;
  logic         Done;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [3:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] out;
    logic [7:0] hi;
    logic       z;
    logic       c;
    logic       v;
    int         lat;
  } vec_t;

  alu_iterative #(.W(W)) dut (
    .Clk      (Clk),
    .Reset    (Reset),
    .Start    (Start),
    .OP       (OP),
    .InputA   (InputA),
    .InputB   (InputB),
    .Out      (Out),
    .OutHi    (OutHi),
    .Zero     (Zero),
    .Carry    (Carry),
    .Overflow (Overflow),
    .Busy     (Busy),
    .Done     (Done)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the opcode rules.
  function automatic vec_t model(input logic [3:0] op,
                                 input logic [7:0] a,
                                 input logic [7:0] b);
    vec_t r;
    int ua, ub, sa, sb, s, n;
    ua = int'(a);
    ub = int'(b);
    sa = int'($signed(a));
    sb = int'($signed(b));
    n  = int'(b[2:0]);
    s  = 0;
    r.op = op; r.a = a; r.b = b;
    r.out = '0; r.hi = '0; r.z = 1'b0;
    r.c = 1'b0; r.v = 1'b0; r.lat = 1;
    case (op)
      4'h0: begin
        s = ua + ub; r.out = s[7:0]; r.c = (s > 255);
        r.v = (sa + sb > 127) || (sa + sb < -128);
      end
      4'h1: begin s = ua * 2; r.out = s[7:0]; r.c = a[7]; end
      4'h2: begin s = ua / 2; r.out = s[7:0]; r.c = a[0]; end
      4'h3: r.out = a & b;
      4'h4: r.out = a | b;
      4'h5: r.out = a ^ b;
      4'h6: begin
        s = ua - ub; r.out = s[7:0]; r.c = (ua < ub);
        r.v = (sa - sb > 127) || (sa - sb < -128);
      end
      4'h7: r.out = b;
      4'h8: r.out = (sa < sb) ? 8'd1 : 8'd0;
      4'h9: begin
        s = ua * ub; r.out = s[7:0]; r.hi = s[15:8];
        r.v = (s > 255); r.lat = 8;
      end
      4'hA: begin
        s = ua << n; r.out = s[7:0];
        if (n != 0) begin
          s = (ua >> (8 - n)) & 1; r.c = s[0];
        end
        r.lat = (n > 1) ? n : 1;
      end
      4'hB: begin
        s = ua >> n; r.out = s[7:0];
        if (n != 0) begin
          s = (ua >> (n - 1)) & 1; r.c = s[0];
        end
        r.lat = (n > 1) ? n : 1;
      end
      default: r.out = '0;
    endcase
    r.z = (r.out == 0) && (r.hi == 0);
    return r;
  endfunction

  // Launch one op and wait (bounded) for its Done pulse.
  // lat = edges after the Start-sampling edge until the
  // result edge (0 for single-cycle), -1 on timeout.
  task automatic do_op(input logic [3:0] op, input logic [7:0] a,
                       input logic [7:0] b, output int lat,
                       output int busy_n);
    @(negedge Clk);
    Start = 1'b1; OP = op; InputA = a; InputB = b;
    @(posedge Clk);
    #1;
    Start = 1'b0;
    OP = 4'($urandom); InputA = 8'($urandom); InputB = 8'($urandom);
    lat = -1;
    busy_n = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge Clk);
      if (Done) begin
        lat = c;
        break;
      end
      if (Busy) busy_n++;
      @(posedge Clk);
    end
  endtask

  task automatic check_vec(input string tag, input vec_t e);
    int lat, busy_n, lat_e;
    do_op(e.op, e.a, e.b, lat, busy_n);
    lat_e = (e.lat == 1) ? 0 : e.lat;
    chk({tag, ".lat"}, lat, lat_e);
    chk({tag, ".busy_cycles"}, busy_n, lat_e);
    chk({tag, ".busy_at_done"}, {31'b0, Busy}, 0);
    chk({tag, ".out"}, {24'b0, Out}, {24'b0, e.out});
    chk({tag, ".hi"}, {24'b0, OutHi}, {24'b0, e.hi});
    chk({tag, ".zcv"}, {29'b0, Zero, Carry, Overflow},
        {29'b0, e.z, e.c, e.v});
  endtask

  vec_t tbl [22];

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    int lat, busy_n, ndone;
    logic [7:0] cap_out, cap_hi;
    vec_t e;

    //        op     a      b      out    hi     z     c     v    lat
    tbl[0]  = '{4'h0, 8'h7F, 8'h01, 8'h80, 8'h00, 1'b0, 1'b0, 1'b1, 1};
    tbl[1]  = '{4'h0, 8'hFF, 8'h01, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0, 1};
    tbl[2]  = '{4'h6, 8'h03, 8'h05, 8'hFE, 8'h00, 1'b0, 1'b1, 1'b0, 1};
    tbl[3]  = '{4'h6, 8'h80, 8'h01, 8'h7F, 8'h00, 1'b0, 1'b0, 1'b1, 1};
    tbl[4]  = '{4'h8, 8'h03, 8'h05, 8'h01, 8'h00, 1'b0, 1'b0, 1'b0, 1};
    tbl[5]  = '{4'h8, 8'h80, 8'h01, 8'h01, 8'h00, 1'b0, 1'b0, 1'b0, 1};
    tbl[6]  = '{4'h9, 8'h10, 8'h20, 8'h00, 8'h02, 1'b0, 1'b0, 1'b1, 8};
    tbl[7]  = '{4'h9, 8'hFF, 8'hFF, 8'h01, 8'hFE, 1'b0, 1'b0, 1'b1, 8};
    tbl[8]  = '{4'h9, 8'h00, 8'h37, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 8};
    tbl[9]  = '{4'hA, 8'h81, 8'h03, 8'h08, 8'h00, 1'b0, 1'b0, 1'b0, 3};
    tbl[10] = '{4'hA, 8'h81, 8'h00, 8'h81, 8'h00, 1'b0, 1'b0, 1'b0, 1};
    tbl[11] = '{4'hB, 8'h81, 8'h01, 8'h40, 8'h00, 1'b0, 1'b1, 1'b0, 1};
    tbl[12] = '{4'hB, 8'h80, 8'hF7, 8'h01, 8'h00, 1'b0, 1'b0, 1'b0, 7};
    tbl[13] = '{4'h1, 8'h80, 8'h00, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0, 1};
    tbl[14] = '{4'h2, 8'h01, 8'h00, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0, 1};
    tbl[15] = '{4'h5, 8'hAA, 8'hAA, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 1};
    tbl[16] = '{4'h7, 8'h11, 8'h5A, 8'h5A, 8'h00, 1'b0, 1'b0, 1'b0, 1};
    tbl[17] = '{4'hF, 8'h12, 8'h34, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 1};
    tbl[18] = '{4'h3, 8'hF0, 8'h3C, 8'h30, 8'h00, 1'b0, 1'b0, 1'b0, 1};
    tbl[19] = '{4'h4, 8'hF0, 8'h0F, 8'hFF, 8'h00, 1'b0, 1'b0, 1'b0, 1};
    tbl[20] = '{4'hA, 8'h01, 8'h07, 8'h80, 8'h00, 1'b0, 1'b0, 1'b0, 7};
    tbl[21] = '{4'hB, 8'h03, 8'h02, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0, 2};

    Reset = 1'b1; Start = 1'b0; OP = '0; InputA = '0; InputB = '0;
    repeat (3) @(posedge Clk);
    #1 Reset = 1'b0;
    @(negedge Clk);
    chk("reset.outs", {8'b0, Out, OutHi}, 32'h0);
    chk("reset.flags", {27'b0, Zero, Carry, Overflow, Busy, Done}, 0);

    for (int i = 0; i < 22; i++)
      check_vec($sformatf("vec%0d", i), tbl[i]);

    for (int i = 0; i < 150; i++) begin
      e = model(4'($urandom_range(0, 15)), 8'($urandom), 8'($urandom));
      check_vec($sformatf("rnd%0d_op%0h", i, e.op), e);
    end

    // Start pulses while MUL is busy must be ignored.
    @(negedge Clk);
    Start = 1'b1; OP = 4'h9; InputA = 8'h10; InputB = 8'h20;
    @(posedge Clk);
    #1 Start = 1'b0;
    ndone = 0; cap_out = 8'hEE; cap_hi = 8'hEE;
    for (int c = 0; c < 16; c++) begin
      @(negedge Clk);
      if (Done) begin
        ndone++;
        if (ndone == 1) begin cap_out = Out; cap_hi = OutHi; end
      end
      if (c == 2 || c == 3 || c == 5) begin
        Start = 1'b1; OP = 4'h0; InputA = 8'h01; InputB = 8'h01;
      end else begin
        Start = 1'b0;
      end
    end
    chk("busy_ignore.ndone", ndone, 1);
    chk("busy_ignore.out", {16'b0, cap_hi, cap_out}, 32'h0200);

    // Start on the Done cycle is accepted immediately.
    do_op(4'hA, 8'h81, 8'h03, lat, busy_n);
    chk("b2b.first_done", {31'b0, Done}, 1);
    Start = 1'b1; OP = 4'h0; InputA = 8'h7F; InputB = 8'h01;
    @(posedge Clk);
    #1 Start = 1'b0;
    @(negedge Clk);
    chk("b2b.second_done", {31'b0, Done}, 1);
    chk("b2b.out", {24'b0, Out}, 32'h80);
    chk("b2b.ovf", {31'b0, Overflow}, 1);
    @(negedge Clk);
    chk("b2b.done_one_cycle", {31'b0, Done}, 0);
    chk("b2b.out_held", {24'b0, Out}, 32'h80);

    // Reset mid-MUL: outputs clear, no Done afterwards.
    @(negedge Clk);
    Start = 1'b1; OP = 4'h9; InputA = 8'hFF; InputB = 8'hFF;
    @(posedge Clk);
    #1 Start = 1'b0;
    repeat (3) @(posedge Clk);
    #1 Reset = 1'b1;
    @(posedge Clk);
    #1 Reset = 1'b0;
    @(negedge Clk);
    chk("rst_mid.outs", {8'b0, Out, OutHi}, 32'h0);
    chk("rst_mid.flags", {27'b0, Zero, Carry, Overflow, Busy, Done}, 0);
    ndone = 0;
    for (int c = 0; c < 14; c++) begin
      @(negedge Clk);
      if (Done || Busy) ndone++;
    end
    chk("rst_mid.no_done", ndone, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
